bird_physics_draw: RTL and testbench
====================================

# bird_physics_draw

Parametrised per-frame bird engine for the flappy-bird game datapath. On each frame tick it erases the bird sprite at its old position, then integrates velocity (gravity or flap impulse) and position with ceiling/floor clamping. It redraws the sprite and reports completion. It drives the shared VGA pixel-write bus (`x_out`/`y_out`/`colour_out`/`plot`) and sits between the game-control FSM (frame tick, flap) and the VGA adapter.

## Interface
- `X_W`, 8: x coordinate width
- `Y_W`, 7: y coordinate width (screen row, 0 = top)
- `VY_W`, 6: signed vertical velocity width (positive = downward)
- `COLOUR_W`, 3: colour width
- `BIRD_X`, 20: fixed sprite left column
- `BIRD_W`, 4 / `BIRD_H`, 4: sprite size in pixels
- `Y_START`, 60: bird_y after reset
- `Y_MAX`, 116: lowest legal bird_y (floor = screen height − BIRD_H)
- `GRAVITY`, 1: velocity added per frame
- `JUMP_VY`, 6: flap sets vy to −JUMP_VY
- `MAX_VY`, 8: terminal fall speed (used only with macro, see Configuration)
- `BIRD_COLOUR`, 3'b010 / `BG_COLOUR`, 3'b111

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `frame_tick`  in  1  one-cycle request to run one frame update
- `flap`  in  1  one-cycle jump request, accepted at any time
- `busy`  out  1  high whenever the FSM is not in IDLE
- `done`  out  1  one-cycle pulse when the frame update completes
- `plot`  out  1  pixel write strobe
- `x_out`  out  X_W  pixel x, valid when `plot`=1
- `y_out`  out  Y_W  pixel y, valid when `plot`=1
- `colour_out`  out  COLOUR_W  pixel colour, valid when `plot`=1
- `bird_y`  out  Y_W  current sprite top row
- `bird_vy`  out  VY_W  current signed velocity
- `dead`  out  1  sticky floor-hit flag

## Operation
- Reset values:
  - `bird_y`=Y_START; `bird_vy`=0; `dead`=0
  - `plot`, `busy` and `done`=0
  - `x_out`, `y_out` and `colour_out`=0
  - `flap_pending`=0
  - FSM in IDLE
- States: IDLE → ERASE → PHYS → DRAW → DONE → IDLE.
- IDLE: on `frame_tick`=1, go to ERASE and clear the column/row scan counters. A `frame_tick` in any other state is dropped (not queued).
- ERASE / DRAW scan:
  - One pixel per cycle, column fastest: (BIRD_X+c, bird_y+r), c in 0..BIRD_W−1, r in 0..BIRD_H−1.
  - `plot`=1 throughout, colour BG_COLOUR in ERASE and BIRD_COLOUR in DRAW.
  - Leave the state after pixel (W−1, H−1).
- PHYS (single cycle, `plot`=0):
  - Effective flap = `flap_pending` | `flap`, ignored when `dead`=1.
  - vy_n = effective flap ? −JUMP_VY : bird_vy + GRAVITY.
  - y_n = bird_y + vy_n, computed sign-extended to Y_W+2 bits.
  - If y_n < 0: bird_y=0, vy=0.
  - If y_n ≥ Y_MAX: bird_y=Y_MAX, vy=0, `dead`←1.
  - Otherwise: bird_y=y_n, vy=vy_n.
  - Clear `flap_pending`.
- `flap` outside PHYS sets `flap_pending`. Multiple flaps within one frame collapse into one. Flaps while `dead` are discarded.
- `dead` clears only on `reset`. Once `dead`=1, PHYS leaves bird_y and vy unchanged; the scans still run, so the sprite is redrawn in place.
- DONE: `done`=1 for one cycle, `plot`=0.
- Reset asserted mid-frame aborts the scan immediately, with no further `plot`. Every value returns to its reset value on the next edge.

## Timing
- N = BIRD_W·BIRD_H. For a `frame_tick` sampled at edge t:
  - ERASE plots occur in cycles t+1..t+N.
  - PHYS occurs at t+N+1.
  - DRAW plots occur in cycles t+N+2..t+2N+1.
  - `done` is high in cycle t+2N+2.
  - `busy` is high from t+1 to t+2N+2.
- With the defaults, `done` comes 34 cycles after the tick and the earliest accepted next tick is at t+2N+3.
- All outputs are registered, and `x_out`/`y_out`/`colour_out` are coincident with `plot`.
- `bird_y`/`bird_vy` change only on the PHYS edge.

## Configuration
- `BIRD_TERMINAL_VEL_EN` defined: after gravity, vy_n is saturated to at most +MAX_VY. Flap values are unaffected.
- Not defined: there is no fall-speed limit, and vy_n saturates only at the VY_W signed maximum, with no wrap.

## Test plan
- Reset, 3 ticks, no flap → vy 1,2,3; bird_y 61,63,66; `dead`=0.
- Reset, `flap` pulsed mid-ERASE, then tick → PHYS gives vy=−6, bird_y=54. The next tick without flap gives vy=−5, y=49.
- Reset, flap before every tick → bird_y 54,48,…,0 at tick 10. Tick 11 → y=0, vy=0, then flap resumes.
- Free fall from reset:
  - Without macro, tick 10 gives y=115 and tick 11 gives y=116, vy=0, `dead`=1.
  - With macro, vy caps at 8 from tick 8 onward (y=96,104,112, then 116 with `dead` at tick 11).
  - After `dead`, flap and further ticks leave y=116.
- Single tick from reset:
  - 16 ERASE plots at x 20..23, y 60..63, colour 7, column-fastest.
  - One idle cycle.
  - 16 DRAW plots at y 61..64, colour 2.
  - `done` at t+34.
  - A second `frame_tick` at t+10 produces no extra plots.
- `reset` asserted at t+20 → `plot`=0 from t+21, bird_y=60, `busy`=0.

Source files
------------

// File: rtl/bird_physics_draw.sv
// bird_physics_draw -- per-frame bird engine for the flappy-bird datapath.
// Each frame_tick runs: erase sprite at old position, integrate velocity and
// position (gravity or flap, ceiling/floor clamp), redraw sprite, pulse done.
// Pixels leave on the shared VGA write bus (plot/x_out/y_out/colour_out).
// Optional feature: define BIRD_TERMINAL_VEL_EN to cap fall speed at MAX_VY.
module bird_physics_draw #(
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  VY_W        = 6,
  parameter int                  COLOUR_W    = 3,
  parameter int                  BIRD_X      = 20,
  parameter int                  BIRD_W      = 4,
  parameter int                  BIRD_H      = 4,
  parameter int                  Y_START     = 60,
  parameter int                  Y_MAX       = 116,
  parameter int                  GRAVITY     = 1,
  parameter int                  JUMP_VY     = 6,
  parameter int                  MAX_VY      = 8,
  parameter logic [COLOUR_W-1:0] BIRD_COLOUR = 3'b010,
  parameter logic [COLOUR_W-1:0] BG_COLOUR   = 3'b111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic                flap,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic [Y_W-1:0]      bird_y,
  output logic [VY_W-1:0]     bird_vy,
  output logic                dead
);

  localparam int CW = $clog2(BIRD_W + 1);
  localparam int RW = $clog2(BIRD_H + 1);
  localparam int VS = VY_W + 1;   // headroom for vy + GRAVITY before saturation
  localparam int YS = Y_W + 2;    // sign bit + one overflow bit for bird_y + vy

  localparam int VY_POS_MAX = (1 << (VY_W - 1)) - 1;
  localparam int VY_NEG_MIN = -(1 << (VY_W - 1));
`ifdef BIRD_TERMINAL_VEL_EN
  localparam int VY_CAP = (MAX_VY < VY_POS_MAX) ? MAX_VY : VY_POS_MAX;
`else
  localparam int VY_CAP = VY_POS_MAX;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_PHYS,
    S_DRAW,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   col, col_n;
  logic [RW-1:0]   row, row_n;
  logic            scan_last;
  logic            flap_pending;

  // physics results, only committed on the PHYS edge
  logic                   flap_eff;
  logic signed [VS-1:0]   vy_sum;
  logic signed [VY_W-1:0] vy_fall;
  logic signed [VY_W-1:0] vy_new;
  logic signed [YS-1:0]   y_sum;
  logic [Y_W-1:0]         y_phys;
  logic [VY_W-1:0]        vy_phys;
  logic                   dead_phys;
  logic [Y_W-1:0]         bird_y_next;

  // next-cycle pixel bus values (registered below so outputs are glitch-free)
  logic                plot_n;
  logic [X_W-1:0]      x_n;
  logic [Y_W-1:0]      y_n;
  logic [COLOUR_W-1:0] colour_n;

  // velocity/position integration with saturation and ceiling/floor clamp
  always_comb begin
    flap_eff  = (flap_pending | flap) & ~dead;
    vy_sum    = VS'($signed(bird_vy)) + VS'(GRAVITY);
    if (vy_sum > VS'(VY_CAP))
      vy_fall = VY_W'(VY_CAP);
    else if (vy_sum < VS'(VY_NEG_MIN))
      vy_fall = VY_W'(VY_NEG_MIN);
    else
      vy_fall = vy_sum[VY_W-1:0];
    vy_new    = flap_eff ? VY_W'(-JUMP_VY) : vy_fall;
    y_sum     = $signed({2'b00, bird_y}) + YS'(vy_new);
    y_phys    = bird_y;
    vy_phys   = bird_vy;
    dead_phys = dead;
    if (!dead) begin
      if (y_sum < 0) begin
        y_phys  = '0;
        vy_phys = '0;
      end else if (y_sum >= YS'(Y_MAX)) begin
        y_phys    = Y_W'(Y_MAX);
        vy_phys   = '0;
        dead_phys = 1'b1;
      end else begin
        y_phys  = y_sum[Y_W-1:0];
        vy_phys = vy_new;
      end
    end
  end

  // sequencer: next state and scan counters (column fastest)
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    scan_last = (col == CW'(BIRD_W - 1)) && (row == RW'(BIRD_H - 1));
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          state_n = S_ERASE;
          col_n   = '0;
          row_n   = '0;
        end
      end
      S_ERASE, S_DRAW: begin
        if (scan_last) begin
          state_n = (state == S_ERASE) ? S_PHYS : S_DONE;
          col_n   = '0;
          row_n   = '0;
        end else if (col == CW'(BIRD_W - 1)) begin
          col_n = '0;
          row_n = row + 1'b1;
        end else begin
          col_n = col + 1'b1;
        end
      end
      S_PHYS:  state_n = S_DRAW;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // pixel bus for the next cycle; DRAW uses the freshly integrated bird_y
  always_comb begin
    bird_y_next = (state == S_PHYS) ? y_phys : bird_y;
    plot_n      = (state_n == S_ERASE) || (state_n == S_DRAW);
    x_n         = '0;
    y_n         = '0;
    colour_n    = '0;
    if (plot_n) begin
      x_n      = X_W'(BIRD_X) + X_W'(col_n);
      y_n      = bird_y_next + Y_W'(row_n);
      colour_n = (state_n == S_ERASE) ? BG_COLOUR : BIRD_COLOUR;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      plot       <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      plot       <= plot_n;
      x_out      <= x_n;
      y_out      <= y_n;
      colour_out <= colour_n;
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

  // bird state commits on PHYS; flaps latch until consumed there
  always_ff @(posedge clk) begin
    if (reset) begin
      bird_y       <= Y_W'(Y_START);
      bird_vy      <= '0;
      dead         <= 1'b0;
      flap_pending <= 1'b0;
    end else if (state == S_PHYS) begin
      bird_y       <= y_phys;
      bird_vy      <= vy_phys;
      dead         <= dead_phys;
      flap_pending <= 1'b0;
    end else if (flap && !dead) begin
      flap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bird_physics_draw.sv
// Directed bench for bird_physics_draw: reset, physics sequences, scan timing,
// dropped ticks, back-to-back frames and mid-frame reset.
module tb_bird_physics_draw;

  logic       clk = 1'b0;
  logic       reset, frame_tick, flap;
  logic       busy, done, plot, dead;
  logic [7:0] x_out;
  logic [6:0] y_out, bird_y;
  logic [2:0] colour_out;
  logic [5:0] bird_vy;

  int vecs = 0;
  int errs = 0;

  bird_physics_draw dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .flap(flap),
    .busy(busy), .done(done), .plot(plot), .x_out(x_out), .y_out(y_out),
    .colour_out(colour_out), .bird_y(bird_y), .bird_vy(bird_vy), .dead(dead)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      vecs++; errs++;
      $display("FAIL wait_done: done not seen within 200 cycles (done=%b)", done);
    end
  endtask

  // optional flap pulse while idle, then one frame; returns in IDLE
  task automatic frame(input logic fl);
    if (fl) begin
      flap = 1'b1; step(); flap = 1'b0;
    end
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    wait_done();
    step();
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({bird_y, bird_vy, dead, plot, busy, done, x_out, y_out, colour_out} !==
        {7'd60, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0}) begin
      errs++;
      $display("FAIL reset: y=%0d vy=%0d dead=%b plot=%b busy=%b done=%b x=%0d yo=%0d c=%0d expected y=60 vy=0 rest 0",
               bird_y, bird_vy, dead, plot, busy, done, x_out, y_out, colour_out);
    end
  endtask

  task automatic test_fall();
    int ey[3] = '{61, 63, 66};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      frame(1'b0);
      vecs++;
      if (bird_y !== 7'(ey[k]) || bird_vy !== 6'(k + 1) || dead !== 1'b0) begin
        errs++;
        $display("FAIL fall[%0d]: y=%0d vy=%0d dead=%b expected y=%0d vy=%0d dead=0",
                 k, bird_y, bird_vy, dead, ey[k], k + 1);
      end
    end
  endtask

  task automatic test_flap_mid_erase();
    do_reset();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    step(); step(); step();
    flap = 1'b1; step(); flap = 1'b0;
    wait_done(); step();
    vecs++;
    if (bird_y !== 7'd54 || bird_vy !== 6'h3a) begin
      errs++;
      $display("FAIL flap_mid_erase: y=%0d vy=%h expected y=54 vy=3a", bird_y, bird_vy);
    end
    frame(1'b0);
    vecs++;
    if (bird_y !== 7'd49 || bird_vy !== 6'h3b) begin
      errs++;
      $display("FAIL flap_next_frame: y=%0d vy=%h expected y=49 vy=3b", bird_y, bird_vy);
    end
  endtask

  task automatic test_ceiling();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      frame(1'b1);
      vecs++;
      if (bird_y !== 7'(60 - 6 * k) || bird_vy !== 6'h3a) begin
        errs++;
        $display("FAIL ceiling[%0d]: y=%0d vy=%h expected y=%0d vy=3a", k, bird_y, bird_vy, 60 - 6 * k);
      end
    end
    frame(1'b1);
    vecs++;
    if (bird_y !== 7'd0 || bird_vy !== 6'd0 || dead !== 1'b0) begin
      errs++;
      $display("FAIL ceiling_clamp: y=%0d vy=%h dead=%b expected y=0 vy=0 dead=0", bird_y, bird_vy, dead);
    end
    frame(1'b0);
    vecs++;
    if (bird_y !== 7'd1 || bird_vy !== 6'd1) begin
      errs++;
      $display("FAIL ceiling_resume: y=%0d vy=%h expected y=1 vy=1", bird_y, bird_vy);
    end
  endtask

  task automatic test_floor();
`ifdef BIRD_TERMINAL_VEL_EN
    int ey[11]  = '{61, 63, 66, 70, 75, 81, 88, 96, 104, 112, 116};
    int evy[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 0};
`else
    int ey[11]  = '{61, 63, 66, 70, 75, 81, 88, 96, 105, 115, 116};
    int evy[11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0};
`endif
    do_reset();
    for (int k = 0; k < 11; k++) begin
      frame(1'b0);
      vecs++;
      if (bird_y !== 7'(ey[k]) || bird_vy !== 6'(evy[k]) || dead !== (k == 10)) begin
        errs++;
        $display("FAIL floor[%0d]: y=%0d vy=%0d dead=%b expected y=%0d vy=%0d dead=%b",
                 k + 1, bird_y, bird_vy, dead, ey[k], evy[k], k == 10);
      end
    end
    frame(1'b1);
    frame(1'b0);
    vecs++;
    if (bird_y !== 7'd116 || bird_vy !== 6'd0 || dead !== 1'b1) begin
      errs++;
      $display("FAIL dead_frozen: y=%0d vy=%0d dead=%b expected y=116 vy=0 dead=1", bird_y, bird_vy, dead);
    end
  endtask

  // cycle-by-cycle check of one frame; a stray tick arrives at t+10
  task automatic test_scan();
    logic [22:0] act, exp;
    logic        e_plot, e_busy, e_done;
    int          ex, ey, ec, eby;
    do_reset();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    for (int cyc = 0; cyc <= 36; cyc++) begin
      e_plot = 1'b0; e_busy = (cyc <= 33); e_done = (cyc == 33);
      ex = 0; ey = 0; ec = 0; eby = (cyc <= 16) ? 60 : 61;
      if (cyc < 16) begin
        e_plot = 1'b1; ex = 20 + cyc % 4; ey = 60 + cyc / 4; ec = 7;
      end else if (cyc >= 17 && cyc <= 32) begin
        e_plot = 1'b1; ex = 20 + (cyc - 17) % 4; ey = 61 + (cyc - 17) / 4; ec = 2;
      end
      exp = {e_plot, 8'(ex), 7'(ey), 3'(ec), e_busy, e_done, 1'b0};
      act = {plot, x_out & {8{e_plot}}, y_out & {7{e_plot}}, colour_out & {3{e_plot}},
             busy, done, 1'b0};
      vecs++;
      if (act !== exp || bird_y !== 7'(eby)) begin
        errs++;
        $display("FAIL scan[t+%0d]: plot=%b x=%0d y=%0d c=%0d busy=%b done=%b by=%0d expected plot=%b x=%0d y=%0d c=%0d busy=%b done=%b by=%0d",
                 cyc, plot, x_out, y_out, colour_out, busy, done, bird_y,
                 e_plot, ex, ey, ec, e_busy, e_done, eby);
      end
      frame_tick = (cyc == 9);
      if (cyc < 36) step();
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    wait_done();
    frame_tick = 1'b1; step();
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++;
      $display("FAIL tick_in_done: busy=%b done=%b expected busy=0 done=0", busy, done);
    end
    step(); frame_tick = 1'b0;
    vecs++;
    if (busy !== 1'b1 || plot !== 1'b1 || y_out !== 7'd61) begin
      errs++;
      $display("FAIL tick_at_2N3: busy=%b plot=%b y=%0d expected busy=1 plot=1 y=61", busy, plot, y_out);
    end
    wait_done(); step();
    vecs++;
    if (bird_y !== 7'd63 || bird_vy !== 6'd2) begin
      errs++;
      $display("FAIL back_to_back: y=%0d vy=%0d expected y=63 vy=2", bird_y, bird_vy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (19) step();
    vecs++;
    if (plot !== 1'b1 || bird_y !== 7'd61) begin
      errs++;
      $display("FAIL pre_reset[t+19]: plot=%b y=%0d expected plot=1 y=61", plot, bird_y);
    end
    reset = 1'b1; step();
    vecs++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bird_y !== 7'd60 || bird_vy !== 6'd0) begin
      errs++;
      $display("FAIL reset_mid: plot=%b busy=%b done=%b y=%0d vy=%0d expected plot=0 busy=0 done=0 y=60 vy=0",
               plot, busy, done, bird_y, bird_vy);
    end
    reset = 1'b0; step(); step();
    vecs++;
    if (plot !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL post_reset: plot=%b busy=%b expected 0 0", plot, busy);
    end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; flap = 1'b0;
    test_reset();
    test_fall();
    test_flap_mid_erase();
    test_ceiling();
    test_floor();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
